// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED-sharing round-robin arbiter.
// The one-hot state encoding is exported on state_dbg so checkers can bind to it.
package led_arb_pkg;

   localparam int N_REQ = 4;
   localparam int PTR_W = $clog2(N_REQ);

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_SHOW = 3'b010,
      ST_GAP  = 3'b100
   } state_e;

   // First set request strictly after ptr, wrapping; ptr itself is checked last.
   function automatic logic [PTR_W-1:0] rr_next(input logic [N_REQ-1:0] req,
                                                input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] win;
      logic             found;
      win   = ptr;
      found = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = ptr + PTR_W'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Cycle and tick counters for one display window; clr forces both to zero,
// en advances them. window_end flags the last cycle of the last tick.
module led_tick_gen #(
   parameter int TICK_CYCLES = 50_000_000,
   parameter int HOLD_TICKS  = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick_pulse,
   output logic window_end,
   output logic tick_odd
);

   localparam int CW = $clog2(TICK_CYCLES);
   localparam int TW = $clog2(HOLD_TICKS) + 1;

   logic [CW-1:0] cycle_q, cycle_d;
   logic [TW-1:0] tick_q, tick_d;
   logic          last_cycle;

   assign last_cycle = (cycle_q == CW'(TICK_CYCLES - 1));
   assign tick_pulse = en & last_cycle;
   assign window_end = tick_pulse & (tick_q == TW'(HOLD_TICKS - 1));
   assign tick_odd   = tick_q[0];

   always_comb begin
      cycle_d = cycle_q;
      tick_d  = tick_q;
      if (clr) begin
         cycle_d = '0;
         tick_d  = '0;
      end else if (en) begin
         if (last_cycle) begin
            cycle_d = '0;
            tick_d  = tick_q + TW'(1);
         end else begin
            cycle_d = cycle_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q <= '0;
         tick_q  <= '0;
      end else begin
         cycle_q <= cycle_d;
         tick_q  <= tick_d;
      end
   end

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the 4-bit LED bank: one requester's latched pattern per window.
// Optional macro LED_ARB_BLINK_EN: blink the pattern on odd ticks of the window.
module led_share_arbiter
   import led_arb_pkg::*;
#(
   parameter int         TICK_CYCLES  = 50_000_000,
   parameter int         HOLD_TICKS   = 2,
   parameter logic [3:0] IDLE_PATTERN = 4'b0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [15:0] pat,
   output logic [3:0]  grant,
   output logic [3:0]  done,
   output logic        busy,
   output logic [3:0]  led,
   output logic [2:0]  state_dbg
);

   // Handshake: a requester raises req[i] and holds it (with a stable pat nibble)
   // until done[i] pulses; dropping req[i] while granted aborts the window.

`ifdef LED_ARB_BLINK_EN
   localparam logic BLINK_EN = 1'b1;
`else
   localparam logic BLINK_EN = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [3:0]        grant_q, grant_d;
   logic [3:0]        done_q, done_d;
   logic              busy_q, busy_d;
   logic [3:0]        led_q, led_d;
   logic [3:0]        pat_q, pat_d;

   logic [PTR_W-1:0]  winner;
   logic [3:0]        pat_sel;
   logic              tick_pulse;
   logic              window_end;
   logic              tick_odd;
   logic              show;

   assign show    = (state_q == ST_SHOW);
   assign winner  = rr_next(req, ptr_q);
   assign pat_sel = pat[{winner, 2'b00} +: 4];

   led_tick_gen #(
      .TICK_CYCLES (TICK_CYCLES),
      .HOLD_TICKS  (HOLD_TICKS)
   ) u_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (!show),
      .en         (show),
      .tick_pulse (tick_pulse),
      .window_end (window_end),
      .tick_odd   (tick_odd)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      done_d  = '0;
      busy_d  = busy_q;
      led_d   = led_q;
      pat_d   = pat_q;
      case (state_q)
         ST_IDLE: begin
            led_d = IDLE_PATTERN;
            if (req != '0) begin
               grant_d = 4'b0001 << winner;
               ptr_d   = winner;
               pat_d   = pat_sel;
               led_d   = pat_sel;
               busy_d  = 1'b1;
               state_d = ST_SHOW;
            end
         end
         ST_SHOW: begin
            // Abort is checked first so a drop on the final cycle never yields done.
            if ((req & grant_q) == '0) begin
               grant_d = '0;
               busy_d  = 1'b0;
               led_d   = IDLE_PATTERN;
               state_d = ST_GAP;
            end else if (window_end) begin
               done_d  = grant_q;
               grant_d = '0;
               busy_d  = 1'b0;
               led_d   = IDLE_PATTERN;
               state_d = ST_GAP;
            end else if (tick_pulse) begin
               // The tick about to start is odd when the current one is even.
               led_d = (BLINK_EN && !tick_odd) ? IDLE_PATTERN : pat_q;
            end
         end
         ST_GAP: begin
            grant_d = '0;
            busy_d  = 1'b0;
            led_d   = IDLE_PATTERN;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            busy_d  = 1'b0;
            led_d   = IDLE_PATTERN;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_W'(N_REQ - 1);
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         led_q   <= IDLE_PATTERN;
         pat_q   <= IDLE_PATTERN;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
         pat_q   <= pat_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign led       = led_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter with TICK_CYCLES=4, HOLD_TICKS=2 (8-cycle windows).
// Per-cycle vector table plus a hand-written asynchronous reset sequence.
module tb_led_share_arbiter;

   localparam int          TICK_CYCLES = 4;
   localparam int          HOLD_TICKS  = 2;
   localparam logic [15:0] P           = 16'h3C5A;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] pat;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic [3:0]  led;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] pat;
      logic [3:0]  grant;
      logic [3:0]  done;
      logic        busy;
      logic [3:0]  led;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   led_share_arbiter #(
      .TICK_CYCLES  (TICK_CYCLES),
      .HOLD_TICKS   (HOLD_TICKS),
      .IDLE_PATTERN (4'b0000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .pat       (pat),
      .grant     (grant),
      .done      (done),
      .busy      (busy),
      .led       (led),
      .state_dbg (state_dbg)
   );

   // Expected LED during window cycle c for latched pattern p.
   function automatic logic [3:0] show_led(input logic [3:0] p, input int c);
`ifdef LED_ARB_BLINK_EN
      return (((c / TICK_CYCLES) % 2) == 0) ? p : 4'b0000;
`else
      return p;
`endif
   endfunction

   function automatic logic [3:0] pat_of(input logic [3:0] g);
      logic [15:0] pv;
      pv = P;
      case (g)
         4'b0001: return pv[3:0];
         4'b0010: return pv[7:4];
         4'b0100: return pv[11:8];
         default: return pv[15:12];
      endcase
   endfunction

   task automatic add_vec(input logic [3:0] r, input logic [15:0] p, input logic [3:0] g,
                          input logic [3:0] d, input logic b, input logic [3:0] l);
      vec_t v;
      v.req = r; v.pat = p; v.grant = g; v.done = d; v.busy = b; v.led = l;
      vecs.push_back(v);
   endtask

   task automatic add_window(input logic [3:0] r, input logic [15:0] p, input logic [3:0] g,
                             input logic [3:0] latched, input int c0, input int c1);
      for (int c = c0; c <= c1; c++) add_vec(r, p, g, 4'b0000, 1'b1, show_led(latched, c));
   endtask

   task automatic check_out(input string name, input logic [3:0] g, input logic [3:0] d,
                            input logic b, input logic [3:0] l);
      n_checks++;
      if (grant !== g || done !== d || busy !== b || led !== l) begin
         n_fail++;
         $display("FAIL %s: got grant=%b done=%b busy=%b led=%b, expected grant=%b done=%b busy=%b led=%b",
                  name, grant, done, busy, led, g, d, b, l);
      end
   endtask

   task automatic check_state(input string name, input logic [2:0] s);
      n_checks++;
      if (state_dbg !== s) begin
         n_fail++;
         $display("FAIL %s: got state=%b, expected %b", name, state_dbg, s);
      end
   endtask

   initial begin
      logic [3:0] fair_seq [5];
      fair_seq[0] = 4'b0010; fair_seq[1] = 4'b0100; fair_seq[2] = 4'b1000;
      fair_seq[3] = 4'b0001; fair_seq[4] = 4'b0010;

      rst_n = 1'b0;
      req   = 4'b0000;
      pat   = P;
      #12;
      check_out("reset_outputs", 4'b0000, 4'b0000, 1'b0, 4'b0000);
      check_state("reset_state", 3'b001);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle with no requests.
      add_vec(4'b0000, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      add_vec(4'b0000, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      // Single request; pat changes after the latch edge must not reach led.
      add_window(4'b0001, P, 4'b0001, 4'b1010, 0, 0);
      add_window(4'b0001, 16'h3C55, 4'b0001, 4'b1010, 1, 7);
      add_vec(4'b0001, P, 4'b0000, 4'b0001, 1'b0, 4'b0000);
      add_vec(4'b0001, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      // Still requesting: regranted two cycles after grant fell.
      add_window(4'b0001, P, 4'b0001, 4'b1010, 0, 7);
      add_vec(4'b0001, P, 4'b0000, 4'b0001, 1'b0, 4'b0000);
      add_vec(4'b1111, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      // All requesting: pointer sits at 0, so rotation starts at requester 1.
      for (int k = 0; k < 5; k++) begin
         add_window(4'b1111, P, fair_seq[k], pat_of(fair_seq[k]), 0, 7);
         add_vec(4'b1111, P, 4'b0000, fair_seq[k], 1'b0, 4'b0000);
         add_vec(4'b1111, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      end
      // Requester 2 aborts during window cycle 3: no done, requester 3 is next.
      add_window(4'b1111, P, 4'b0100, pat_of(4'b0100), 0, 3);
      add_vec(4'b1011, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      add_vec(4'b1011, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      // Requester 3 drops on the final window cycle: abort wins, no done.
      add_window(4'b1011, P, 4'b1000, pat_of(4'b1000), 0, 7);
      add_vec(4'b0011, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);
      add_vec(4'b0000, P, 4'b0000, 4'b0000, 1'b0, 4'b0000);

      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req;
         pat = vecs[i].pat;
         @(posedge clk);
         #1;
         check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].done, vecs[i].busy, vecs[i].led);
      end

      // Reset mid-window; pointer must return to 3 so requester 1 wins over 3.
      req = 4'b0010;
      @(posedge clk);
      #1 check_out("rst_seq_grant", 4'b0010, 4'b0000, 1'b1, 4'b0101);
      check_state("rst_seq_show", 3'b010);
      repeat (5) @(posedge clk);
      #1 check_out("rst_seq_cycle5", 4'b0010, 4'b0000, 1'b1, show_led(4'b0101, 5));
      #2 rst_n = 1'b0;
      #1 check_out("rst_seq_async", 4'b0000, 4'b0000, 1'b0, 4'b0000);
      check_state("rst_seq_async_state", 3'b001);
      req = 4'b1010;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 check_out("rst_seq_after", 4'b0010, 4'b0000, 1'b1, 4'b0101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_share_arbiter.md
# led_share_arbiter

Round-robin arbiter that shares the board's 4-bit LED bank between four pattern requesters. Each requester asks for the LEDs with a req/grant handshake. The winner's pattern is shown for a fixed window of 1 s ticks, then the LEDs are released to the next requester. The block sits between the per-mode LED pattern FSMs and the LED pins, and replaces direct LED drive by any single FSM.

## Interface
Parameters:
- TICK_CYCLES, default 50_000_000: clk cycles per tick (1 s at 50 MHz); must be ≥2.
- HOLD_TICKS, default 2: ticks per display window; must be ≥1.
- IDLE_PATTERN, default 4'b0000: LED value when nothing is shown.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- req, in, 4: request per requester; held high until done or abort.
- pat, in, 16: requester i pattern in pat[4i+3:4i]; must be stable while req[i] is high.
- grant, out, 4: one-hot, high for the whole display window.
- done, out, 4: one-cycle completion pulse to the requester whose window expired.
- busy, out, 1: high while in SHOW.
- led, out, 4: registered LED drive.

## Operation
- Reset values: state IDLE, grant 0, done 0, busy 0, led IDLE_PATTERN, RR pointer 3 (requester 0 has highest priority first), counters 0.
- States are IDLE, SHOW, GAP.
- IDLE, when req≠0:
  - Pick the first set req bit searching from pointer+1, wrapping 3→0.
  - On the same edge: grant←onehot(winner), pointer←winner, latch pattern, led←pattern, busy←1, cycle and tick counters←0, go to SHOW.
  - req=0: stay in IDLE, led=IDLE_PATTERN.
- SHOW:
  - The cycle counter counts 0..TICK_CYCLES-1 and wraps; each wrap increments the tick counter.
  - The window ends on the cycle where tick = HOLD_TICKS-1 and cycle = TICK_CYCLES-1. SHOW therefore lasts exactly HOLD_TICKS×TICK_CYCLES cycles.
  - At the end edge: grant←0, done←same one-hot, busy←0, led←IDLE_PATTERN, go to GAP.
- Abort: if req of the granted requester is sampled low during SHOW, then on that edge grant←0, busy←0, led←IDLE_PATTERN, no done pulse, go to GAP. Abort takes priority over window end in the same cycle.
- GAP: lasts one cycle. done clears on the exit edge. Go to IDLE unconditionally.
- Requests that stay high after done are re-arbitrated normally. The pointer has already advanced, so other requesters are served first.
- pat changes while granted are ignored; only the latched copy drives led.
- Counter widths: cycle $clog2(TICK_CYCLES), tick $clog2(HOLD_TICKS)+1. No overflow is possible because both counters clear on SHOW entry.

## Timing
- req rising before edge k: grant, busy and led valid after edge k (1-cycle latency).
- grant high for HOLD_TICKS×TICK_CYCLES cycles; done high for exactly 1 cycle, starting the cycle grant falls.
- Minimum grant-to-grant spacing: 2 idle cycles (GAP, then IDLE arbitration).
- Reset asserted mid-SHOW: all outputs return to reset values immediately (asynchronously). The pointer returns to 3.

## Configuration
- LED_ARB_BLINK_EN defined:
  - During SHOW, led shows the latched pattern on even ticks (0, 2, …) and IDLE_PATTERN on odd ticks.
  - led updates on the tick-wrap edge.
  - grant, done and window length are unchanged.
- LED_ARB_BLINK_EN undefined: led shows the latched pattern steadily for the whole SHOW window.

## Structure
- Package led_arb_pkg holds:
  - state encoding, one-hot 3 bits: IDLE=3'b001, SHOW=3'b010, GAP=3'b100
  - N_REQ=4
  - the round-robin next-winner function
- Sub-module led_tick_gen: cycle and tick counters with clear input, tick_pulse and window_end outputs. The arbiter FSM instantiates it once.

## Test plan
All scenarios use TICK_CYCLES=4 and HOLD_TICKS=2, so SHOW lasts 8 cycles.
- Single request: req=0001, pat[3:0]=4'b1010 → grant=0001 and led=1010 one cycle later for 8 cycles; then done=0001 for 1 cycle with led=0000; grant returns 2 cycles later if req is still high.
- Round-robin fairness: req=1111 held → grant sequence 0001, 0010, 0100, 1000, 0001, each grant with its own pattern and a done pulse.
- Abort: req[2] drops in cycle 3 of its window → grant=0 next cycle, done stays 0, led=IDLE_PATTERN, next requester is served after GAP.
- Simultaneous end and abort: req drops in the final SHOW cycle → no done pulse.
- Reset mid-SHOW: rst_n low in cycle 5 → grant, done, busy, led (0000) cleared immediately; after release, req=1010 is granted to requester 1 first.
- LED_ARB_BLINK_EN defined, pattern 4'b0110 → led=0110 for cycles 0-3 and 0000 for cycles 4-7 of the window.
